// File: rtl/k_fifo_wmem_writer.sv
// Drains 8-bit channel bytes from the output FIFO, packs them into {r,g,b} pixels
// and writes them sequentially into the banked write-data memory, one frame per start.
module k_fifo_wmem_writer #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int NUM_BANKS = 4,
   parameter int BANK_W    = 2
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W+BANK_W-1:0] frame_len,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [BANK_W-1:0]        base_bank,
   input  logic                     fifo_empty,
   output logic                     fifo_read_enable,
   input  logic [DATA_W-1:0]        fifo_read_data,
   input  logic                     mem_ready,
   output logic                     mem_write_enable,
   output logic [BANK_W-1:0]        mem_bank,
   output logic [ADDR_W-1:0]        mem_write_address,
   output logic [3*DATA_W-1:0]      mem_write_data,
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_W+BANK_W-1:0] pixel_count
);

   localparam int CNT_W = ADDR_W + BANK_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_frame_len;
   logic [CNT_W-1:0]    r_pix_cnt;
   logic [CNT_W-1:0]    w_pix_cnt_inc;
   logic [ADDR_W-1:0]   r_addr;
   logic [BANK_W-1:0]   r_bank;
   logic [BANK_W-1:0]   w_bank_inc;
   logic [1:0]          r_chan_idx;
   logic                r_busy;
   logic                r_done;

   assign w_pix_cnt_inc = r_pix_cnt + 1'b1;
   assign w_bank_inc    = (r_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_bank + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      fifo_read_enable = 1'b0;
      mem_write_enable = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (frame_len == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (!fifo_empty) begin
               fifo_read_enable = 1'b1;
               w_state_next     = S_WAIT;
            end
         end
         S_WAIT: begin
            w_state_next = (r_chan_idx == 2'd2) ? S_WRITE : S_REQ;
         end
         S_WRITE: begin
            mem_write_enable = 1'b1;
            if (mem_ready) begin
               w_state_next = (w_pix_cnt_inc == r_frame_len) ? S_DONE : S_REQ;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Frame bookkeeping; done and busy are registered off the DONE state so they move together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_len <= '0;
         r_pix_cnt   <= '0;
         r_addr      <= '0;
         r_bank      <= '0;
         r_chan_idx  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_frame_len <= frame_len;
                  r_addr      <= base_addr;
                  r_bank      <= base_bank;
                  r_pix_cnt   <= '0;
                  r_chan_idx  <= '0;
                  r_busy      <= 1'b1;
               end
            end
            S_WAIT: begin
               r_chan_idx <= (r_chan_idx == 2'd2) ? 2'd0 : r_chan_idx + 2'd1;
            end
            S_WRITE: begin
               if (mem_ready) begin
                  r_pix_cnt <= w_pix_cnt_inc;
                  if (w_pix_cnt_inc != r_frame_len) begin
                     r_addr <= r_addr + 1'b1;
                     if (r_addr == '1) begin
                        r_bank <= w_bank_inc;
                     end
                  end
               end
            end
            S_DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // One capture register per channel; index 0 is red and lands in the MSBs.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [DATA_W-1:0] r_byte;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_byte <= '0;
            end else if (r_state == S_WAIT && r_chan_idx == 2'(gi)) begin
               r_byte <= fifo_read_data;
            end
         end
      end
   endgenerate

   assign mem_write_data    = {g_chan[0].r_byte, g_chan[1].r_byte, g_chan[2].r_byte};
   assign mem_bank          = r_bank;
   assign mem_write_address = r_addr;
   assign busy              = r_busy;
   assign done              = r_done;
   assign pixel_count       = r_pix_cnt;

endmodule
